// File: rtl/proc_8085_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_8085_seq: 8085-style T-state sequencer for MOV/ALU/MVI/JMP/HLT.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module proc_8085_seq #(
  parameter logic [2:0] REG_A_CODE = 3'b111,
  parameter logic [2:0] REG_B_CODE = 3'b000,
  parameter logic [2:0] REG_C_CODE = 3'b001,
  parameter logic [2:0] REG_D_CODE = 3'b010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  d,
  output logic        ale,
  output logic        rd_n,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] branch_address,
  output logic [2:0]  op1_select,
  output logic [2:0]  op2_select,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  wr_src,
  output logic [7:0]  wr_data,
  output logic        enable_reg_a,
  output logic        enable_reg_b,
  output logic        enable_reg_c,
  output logic        enable_reg_d,
  output logic [1:0]  mcycle,
  output logic        halted
);

  typedef enum logic [2:0] {ST_T1, ST_T2, ST_T3, ST_EX, ST_HALT} state_t;
  typedef enum logic [2:0] {CL_NOP, CL_MOV, CL_ALU, CL_MVI, CL_JMP} cls_t;

  localparam logic [1:0] c_MC_OF  = 2'b00;
  localparam logic [1:0] c_MC_OP1 = 2'b01;
  localparam logic [1:0] c_MC_OP2 = 2'b10;
  localparam logic [1:0] c_MC_HLT = 2'b11;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_mc, w_mc_nx;
  cls_t        r_cls, w_cls_dec;
  logic        w_is_hlt;
  logic [2:0]  r_dst;
  logic [7:0]  r_lo;
  logic [7:0]  r_wr_data;
  logic [2:0]  r_op1, r_op2, r_alu;
  logic [1:0]  r_wr_src;
  logic [15:0] r_ba;
  logic [2:0]  w_dst;
  logic        w_we;

  always_comb begin
    w_is_hlt  = (d == 8'h76);
    w_cls_dec = CL_NOP;
    if (w_is_hlt)
      w_cls_dec = CL_NOP;
    else if (d[7:6] == 2'b01)
      w_cls_dec = CL_MOV;
    else if (d[7:6] == 2'b10)
      w_cls_dec = CL_ALU;
    else if (d[7:6] == 2'b00 && d[2:0] == 3'b110)
      w_cls_dec = CL_MVI;
    else if (d == 8'hC3)
      w_cls_dec = CL_JMP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_T1;
      r_mc    <= c_MC_OF;
    end else begin
      r_state <= w_state_nx;
      r_mc    <= w_mc_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mc_nx    = r_mc;
    case (r_state)
      ST_T1: w_state_nx = ST_T2;
      ST_T2: w_state_nx = ST_T3;
      ST_T3: begin
        case (r_mc)
          c_MC_OF: begin
            if (w_is_hlt) begin
              w_state_nx = ST_HALT;
              w_mc_nx    = c_MC_HLT;
            end else if (w_cls_dec == CL_MVI || w_cls_dec == CL_JMP) begin
              w_state_nx = ST_T1;
              w_mc_nx    = c_MC_OP1;
            end else begin
              w_state_nx = ST_EX;
            end
          end
          c_MC_OP1: begin
            if (r_cls == CL_JMP) begin
              w_state_nx = ST_T1;
              w_mc_nx    = c_MC_OP2;
            end else begin
              w_state_nx = ST_EX;
            end
          end
          default: w_state_nx = ST_EX;
        endcase
      end
      ST_EX: begin
        w_state_nx = ST_T1;
        w_mc_nx    = c_MC_OF;
      end
      ST_HALT: w_state_nx = ST_HALT;
      default: begin
        w_state_nx = ST_T1;
        w_mc_nx    = c_MC_OF;
      end
    endcase
  end

  // Execute-phase controls load on the T3 edge that enters EX, so they are
  // valid throughout EX and simply persist afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cls     <= CL_NOP;
      r_dst     <= 3'b000;
      r_lo      <= 8'h00;
      r_wr_data <= 8'h00;
      r_op1     <= 3'b000;
      r_op2     <= 3'b000;
      r_alu     <= 3'b000;
      r_wr_src  <= 2'b00;
      r_ba      <= 16'h0000;
    end else if (r_state == ST_T3) begin
      case (r_mc)
        c_MC_OF: begin
          r_cls <= w_cls_dec;
          r_dst <= d[5:3];
          if (w_cls_dec == CL_MOV) begin
            r_op2    <= d[2:0];
            r_wr_src <= 2'b10;
          end else if (w_cls_dec == CL_ALU) begin
            r_op1    <= REG_A_CODE;
            r_op2    <= d[2:0];
            r_alu    <= d[5:3];
            r_wr_src <= 2'b00;
          end
        end
        c_MC_OP1: begin
          r_lo <= d;
          if (r_cls == CL_MVI) begin
            r_wr_data <= d;
            r_wr_src  <= 2'b01;
          end
        end
        c_MC_OP2: r_ba <= {d, r_lo};
        default: ;
      endcase
    end
  end

  // Priority chain keeps a single enable even if register codes collide.
  always_comb begin
    w_dst        = r_dst;
    w_we         = 1'b0;
    enable_reg_a = 1'b0;
    enable_reg_b = 1'b0;
    enable_reg_c = 1'b0;
    enable_reg_d = 1'b0;
    if (!reset && r_state == ST_EX) begin
      case (r_cls)
        CL_MOV, CL_MVI: w_we = 1'b1;
        CL_ALU: begin
          w_dst = REG_A_CODE;
          w_we  = (r_dst != 3'b111);
        end
        default: w_we = 1'b0;
      endcase
    end
    if (w_we) begin
      if (w_dst == REG_A_CODE)      enable_reg_a = 1'b1;
      else if (w_dst == REG_B_CODE) enable_reg_b = 1'b1;
      else if (w_dst == REG_C_CODE) enable_reg_c = 1'b1;
      else if (w_dst == REG_D_CODE) enable_reg_d = 1'b1;
    end
  end

  assign ale            = !reset && (r_state == ST_T1);
  assign rd_n           = reset || !(r_state == ST_T2 || r_state == ST_T3);
  assign pc_inc         = !reset && (r_state == ST_T3);
  assign pc_load        = !reset && (r_state == ST_EX) && (r_cls == CL_JMP);
  assign halted         = !reset && (r_state == ST_HALT);
  assign mcycle         = reset ? c_MC_OF : r_mc;
  assign branch_address = reset ? 16'h0000 : r_ba;
  assign op1_select     = reset ? 3'b000 : r_op1;
  assign op2_select     = reset ? 3'b000 : r_op2;
  assign alu_ctrl       = reset ? 3'b000 : r_alu;
  assign wr_src         = reset ? 2'b00 : r_wr_src;
  assign wr_data        = reset ? 8'h00 : r_wr_data;

endmodule
`default_nettype wire

// File: doc/proc_8085_seq.md
PROC_8085_SEQ -- requirements
Module: proc_8085_seq

Interface
REQ-001 SHALL have parameter REG_A_CODE, default 3'b111, register code of A.
REQ-002 SHALL have parameter REG_B_CODE, default 3'b000, register code of B.
REQ-003 SHALL have parameter REG_C_CODE, default 3'b001, register code of C.
REQ-004 SHALL have parameter REG_D_CODE, default 3'b010, register code of D.
REQ-005 SHALL have port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port d, input, 8, memory read data.
REQ-008 SHALL have port ale, output, 1, address latch enable.
REQ-009 SHALL have port rd_n, output, 1, active-low memory read strobe.
REQ-010 SHALL have port pc_inc, output, 1, one-cycle program counter increment pulse.
REQ-011 SHALL have port pc_load, output, 1, one-cycle program counter load pulse.
REQ-012 SHALL have port branch_address, output, 16, jump target, valid while pc_load=1.
REQ-013 SHALL have ports op1_select and op2_select, output, 3 each, register-file read selects.
REQ-014 SHALL have port alu_ctrl, output, 3, ALU operation.
REQ-015 SHALL have port wr_src, output, 2, write source: 00 ALU, 01 wr_data, 10 op2 register.
REQ-016 SHALL have port wr_data, output, 8, latched operand byte.
REQ-017 SHALL have ports enable_reg_a, enable_reg_b, enable_reg_c, enable_reg_d, output, 1 each, one-cycle write enables.
REQ-018 SHALL have port mcycle, output, 2, status: 00 opcode fetch, 01 operand 1, 10 operand 2, 11 halted.
REQ-019 SHALL have port halted, output, 1, high in HALT state.

Function
REQ-020 SHALL implement states T1, T2, T3, EX, HALT; each machine cycle is T1->T2->T3.
REQ-021 SHALL drive ale=1 in T1 only; rd_n=0 in T2 and T3 only; rd_n=1 elsewhere.
REQ-022 SHALL capture d at the end of T3 (into opcode, low or high operand register per mcycle) and pulse pc_inc in T3.
REQ-023 SHALL decode after opcode-fetch T3: 01DDDSSS except 0x76 = MOV, 10OOOSSS = ALU, 00DDD110 = MVI, 0xC3 = JMP, 0x76 = HLT; all other opcodes SHALL be NOP.
REQ-024 SHALL go OF T3 -> EX for MOV, ALU, NOP; OF T3 -> operand-1 T1 for MVI, JMP; OF T3 -> HALT for HLT.
REQ-025 SHALL go MVI operand-1 T3 -> EX; JMP operand-1 T3 -> operand-2 T1; JMP operand-2 T3 -> EX; EX -> OF T1.
REQ-026 SHALL yield latency, OF T1 to next OF T1: 4 cycles for MOV, ALU, NOP; 7 for MVI; 10 for JMP.
REQ-027 SHALL, in EX for MOV, drive op2_select=SSS and wr_src=10, and pulse the enable matching DDD.
REQ-028 SHALL, in EX for ALU, drive op1_select=REG_A_CODE, op2_select=SSS, alu_ctrl=OOO, wr_src=00, and pulse enable_reg_a unless OOO=111 (compare: no write).
REQ-029 SHALL, in EX for MVI, drive wr_src=01, wr_data=operand byte, and pulse the enable matching DDD.
REQ-030 SHALL, in EX for JMP, pulse pc_load with branch_address={high operand, low operand}; low byte is fetched first.
REQ-031 SHALL assert no enable when the destination code matches no REG_x_CODE; at most one enable per cycle.
REQ-032 SHALL never assert pc_inc and pc_load in the same cycle, and SHALL assert no enable outside EX.
REQ-033 SHALL hold HALT (ale=0, rd_n=1, no pulses, halted=1, mcycle=11) until reset.
REQ-034 SHALL hold op1_select, op2_select, alu_ctrl, wr_src and branch_address at their last values outside EX; only enable and pulse outputs qualify action.

Reset
REQ-035 SHALL, while reset=1, force state=T1 with mcycle=00; ale=0, rd_n=1, pc_inc=0, pc_load=0, all enables=0, halted=0; opcode, operand registers, wr_data, branch_address=0; selects, alu_ctrl and wr_src=0.
REQ-036 SHALL abort any instruction mid-cycle, HALT included, with no write or pc pulse, and start an opcode fetch at T1 in the first cycle after reset deasserts.

Verification
REQ-037 SHALL cover MOV B,C: d=0x41 -> enable_reg_b pulse in cycle 4, wr_src=10, op2_select=001, next ale in cycle 5.
REQ-038 SHALL cover MVI D,0x5A: d=0x16 then 0x5A -> 2 pc_inc pulses, enable_reg_d with wr_data=0x5A in cycle 7.
REQ-039 SHALL cover JMP 0x1234: d=0xC3, 0x34, 0x12 -> pc_load with branch_address=0x1234 in cycle 10, 3 pc_inc pulses, no enables.
REQ-040 SHALL cover ALU ops: ADD C (0x81) -> alu_ctrl=000 with enable_reg_a; CMP C (0xB9) -> alu_ctrl=111 with no enable.
REQ-041 SHALL cover HLT then reset: d=0x76 -> halted=1 and mcycle=11 held for 20 cycles; reset for 1 cycle -> ale=1 in the cycle after release.
REQ-042 SHALL cover reset mid-JMP: reset during operand-2 T2 -> no pc_load, restart at OF T1; MOV E,A (0x5F) -> no enable asserted.
